// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP constants: loader state encoding, set length and bank packing helpers
package dsp_pkg;

    // Coefficient loader states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PEND = 2'd2
    } load_state_e;

    // Words per coefficient set: M feed-forward plus M-1 feedback words
    function automatic int set_len(input int m);
        return 2 * m - 1;
    endfunction

    // LSB position of word k in a flat packed bank; the IIR filters unpack with the same rule
    function automatic int slice_lsb(input int k, input int cw);
        return k * cw;
    endfunction

endpackage

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - register file of D coefficient words with word write, parallel load and flat read
module coeff_bank
    import dsp_pkg::*;
#(
    parameter int D  = 3,
    parameter int W  = 14,
    parameter int AW = (D > 1) ? $clog2(D) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [W-1:0]     wdata,
    input  logic             clr,
    input  logic             load,
    input  logic [D*W-1:0]   load_data,
    output logic [D*W-1:0]   rdata
);

    logic [D*W-1:0] mem_q;
    logic [D*W-1:0] mem_d;

    // Clear wins over a full load, which wins over a single-word write
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            mem_d = '0;
        end else if (load) begin
            mem_d = load_data;
        end else if (we) begin
            mem_d[slice_lsb(int'(waddr), W) +: W] = wdata;
        end
    end

    // Storage register, zeroed by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q;

endmodule

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - assembles IIR coefficient sets in a shadow bank and swaps them in on a sample boundary
module iir_coeff_loader
    import dsp_pkg::*;
#(
    parameter int M           = 2,
    parameter int COEFF_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COEFF_WIDTH-1:0]       coeff_in,
    input  logic                         coeff_valid,
    input  logic                         coeff_last,
    output logic                         coeff_ready,
    input  logic                         sample_strobe,
    output logic [M*COEFF_WIDTH-1:0]     packed_b_coeffs,
    output logic [(M-1)*COEFF_WIDTH-1:0] packed_a_coeffs,
    output logic                         swap_done,
    output logic                         load_error
);

    localparam int N     = set_len(M);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int CW    = COEFF_WIDTH;

    load_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               swap_done_q, swap_done_d;
    logic               load_error_q, load_error_d;

    logic               accept;
    logic               is_final;
    logic               shadow_we;
    logic               shadow_clr;
    logic               active_load;
    logic [N*CW-1:0]    shadow_flat;
    logic [N*CW-1:0]    active_flat;

    // ready is registered, so acceptance depends only on the current state
    assign accept   = coeff_valid && ready_q;
    assign is_final = (cnt_q == CNT_W'(N - 1));

    // Next-state, counter and pulse logic; strobes only matter while a full set is pending
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        swap_done_d  = 1'b0;
        load_error_d = 1'b0;
        shadow_we    = 1'b0;
        shadow_clr   = 1'b0;
        active_load  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    if (coeff_last != is_final) begin
                        // Malformed set: drop everything gathered so far
                        load_error_d = 1'b1;
                        shadow_clr   = 1'b1;
                        cnt_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        shadow_we = 1'b1;
                        if (is_final) begin
                            cnt_d   = '0;
                            state_d = PEND;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = LOAD;
                        end
                    end
                end
            end
            PEND: begin
                if (sample_strobe) begin
                    active_load = 1'b1;
                    swap_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d != PEND);
    end

    // Loader FSM with registered handshake and pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            swap_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            swap_done_q  <= swap_done_d;
            load_error_q <= load_error_d;
        end
    end

    coeff_bank #(
        .D (N),
        .W (CW)
    ) u_shadow (
        .clk       (clk),
        .rst       (rst),
        .we        (shadow_we),
        .waddr     (cnt_q),
        .wdata     (coeff_in),
        .clr       (shadow_clr),
        .load      (1'b0),
        .load_data ('0),
        .rdata     (shadow_flat)
    );

    coeff_bank #(
        .D (N),
        .W (CW)
    ) u_active (
        .clk       (clk),
        .rst       (rst),
        .we        (1'b0),
        .waddr     ('0),
        .wdata     ('0),
        .clr       (1'b0),
        .load      (active_load),
        .load_data (shadow_flat),
        .rdata     (active_flat)
    );

    assign packed_b_coeffs = active_flat[M*CW-1:0];
    assign packed_a_coeffs = active_flat[N*CW-1:M*CW];
    assign coeff_ready     = ready_q;
    assign swap_done       = swap_done_q;
    assign load_error      = load_error_q;

endmodule

// File: tb/tb_iir_coeff_loader.sv
// tb/tb_iir_coeff_loader.sv - randomized self-checking bench for iir_coeff_loader against a set-level model
module tb_iir_coeff_loader;

    localparam int M  = 2;
    localparam int CW = 14;
    localparam int N  = 2 * M - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [CW-1:0]        coeff_in = '0;
    logic                 coeff_valid = 1'b0;
    logic                 coeff_last = 1'b0;
    logic                 coeff_ready;
    logic                 sample_strobe = 1'b0;
    logic [M*CW-1:0]      packed_b_coeffs;
    logic [(M-1)*CW-1:0]  packed_a_coeffs;
    logic                 swap_done;
    logic                 load_error;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: what the host has handed over, and what the filter should see
    logic [CW-1:0] active_m [N];
    logic [CW-1:0] shadow_m [N];
    int            idx_m;
    bit            pend_m;
    int            swaps_seen;

    iir_coeff_loader #(.M(M), .COEFF_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .coeff_in        (coeff_in),
        .coeff_valid     (coeff_valid),
        .coeff_last      (coeff_last),
        .coeff_ready     (coeff_ready),
        .sample_strobe   (sample_strobe),
        .packed_b_coeffs (packed_b_coeffs),
        .packed_a_coeffs (packed_a_coeffs),
        .swap_done       (swap_done),
        .load_error      (load_error)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            active_m[i] = '0;
            shadow_m[i] = '0;
        end
        idx_m  = 0;
        pend_m = 0;
    endtask

    // One clock of stimulus; the model decides what the set rules imply and the result is compared
    task automatic apply_cycle(input bit v, input logic [CW-1:0] w, input bit l, input bit s);
        bit e_swap;
        bit e_err;
        logic [2+M*CW+(M-1)*CW:0] got;
        logic [2+M*CW+(M-1)*CW:0] exp;
        e_swap = 0;
        e_err  = 0;
        coeff_valid   = v;
        coeff_in      = w;
        coeff_last    = l;
        sample_strobe = s;
        if (pend_m) begin
            if (s) begin
                for (int i = 0; i < N; i++) active_m[i] = shadow_m[i];
                pend_m = 0;
                e_swap = 1;
            end
        end else if (v) begin
            if (l != (idx_m == N - 1)) begin
                e_err = 1;
                idx_m = 0;
            end else begin
                shadow_m[idx_m] = w;
                if (idx_m == N - 1) begin
                    pend_m = 1;
                    idx_m  = 0;
                end else begin
                    idx_m++;
                end
            end
        end
        @(posedge clk);
        #1;
        coeff_valid   = 1'b0;
        coeff_last    = 1'b0;
        sample_strobe = 1'b0;
        if (swap_done === 1'b1) swaps_seen++;
        got = {coeff_ready, swap_done, load_error, packed_b_coeffs, packed_a_coeffs};
        exp = {!pend_m, e_swap, e_err, active_m[1], active_m[0], active_m[2]};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t ready/swap/err/b/a got %b/%b/%b/%h/%h expected %b/%b/%b/%h/%h",
                     $time, coeff_ready, swap_done, load_error, packed_b_coeffs, packed_a_coeffs,
                     !pend_m, e_swap, e_err, {active_m[1], active_m[0]}, active_m[2]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        coeff_valid = 1'b0;
        sample_strobe = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({coeff_ready, swap_done, load_error, packed_b_coeffs, packed_a_coeffs} !== {3'b100, 42'd0}) begin
            miscompares++;
            $display("FAIL reset_values got ready=%b swap=%b err=%b b=%h a=%h expected 1/0/0/0/0",
                     coeff_ready, swap_done, load_error, packed_b_coeffs, packed_a_coeffs);
        end
        for (int i = 0; i < 20; i++) apply_cycle(0, '0, 0, (i % 3) == 0);
    endtask

    task automatic test_normal();
        apply_cycle(1, 14'd20, 0, 0);
        apply_cycle(1, -14'sd30, 0, 0);
        apply_cycle(1, 14'd5, 1, 0);
        vectors++;
        if (coeff_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL final_word_ready got %b expected 0", coeff_ready);
        end
        for (int i = 0; i < 3; i++) apply_cycle(0, '0, 0, 0);
        apply_cycle(0, '0, 0, 1);
        vectors++;
        if ({swap_done, packed_b_coeffs, packed_a_coeffs} !== {1'b1, 14'h3FE2, 14'd20, 14'd5}) begin
            miscompares++;
            $display("FAIL normal_swap got swap=%b b=%h a=%h expected 1/%h/%h",
                     swap_done, packed_b_coeffs, packed_a_coeffs, {14'h3FE2, 14'd20}, 14'd5);
        end
        apply_cycle(0, '0, 0, 0);
    endtask

    task automatic test_early_last();
        apply_cycle(1, 14'd7, 1, 0);
        vectors++;
        if ({load_error, coeff_ready, packed_b_coeffs, packed_a_coeffs} !== {2'b11, 14'h3FE2, 14'd20, 14'd5}) begin
            miscompares++;
            $display("FAIL early_last got err=%b ready=%b b=%h a=%h expected 1/1/%h/%h",
                     load_error, coeff_ready, packed_b_coeffs, packed_a_coeffs, {14'h3FE2, 14'd20}, 14'd5);
        end
        apply_cycle(1, 14'd1, 0, 0);
        apply_cycle(1, 14'd2, 0, 0);
        apply_cycle(1, 14'd3, 1, 0);
        apply_cycle(0, '0, 0, 1);
        vectors++;
        if ({packed_b_coeffs, packed_a_coeffs} !== {14'd2, 14'd1, 14'd3}) begin
            miscompares++;
            $display("FAIL recover_swap got b=%h a=%h expected %h/%h",
                     packed_b_coeffs, packed_a_coeffs, {14'd2, 14'd1}, 14'd3);
        end
    endtask

    task automatic test_missing_last();
        apply_cycle(1, 14'd1, 0, 0);
        apply_cycle(1, 14'd2, 0, 0);
        apply_cycle(1, 14'd3, 0, 0);
        vectors++;
        if ({load_error, coeff_ready} !== 2'b11) begin
            miscompares++;
            $display("FAIL missing_last got err=%b ready=%b expected 1/1", load_error, coeff_ready);
        end
        apply_cycle(0, '0, 0, 1);
        vectors++;
        if ({swap_done, packed_b_coeffs, packed_a_coeffs} !== {1'b0, 14'd2, 14'd1, 14'd3}) begin
            miscompares++;
            $display("FAIL missing_last_strobe got swap=%b b=%h a=%h expected 0/%h/%h",
                     swap_done, packed_b_coeffs, packed_a_coeffs, {14'd2, 14'd1}, 14'd3);
        end
    endtask

    task automatic test_simul_strobe();
        apply_cycle(1, 14'h1234, 0, 0);
        apply_cycle(1, 14'h2BCD, 0, 0);
        apply_cycle(1, 14'h0F0F, 1, 1);
        vectors++;
        if ({swap_done, coeff_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_strobe got swap=%b ready=%b expected 0/0", swap_done, coeff_ready);
        end
        apply_cycle(1, 14'h3FFF, 0, 0);
        apply_cycle(1, 14'h3FFF, 1, 0);
        apply_cycle(0, '0, 0, 1);
        vectors++;
        if ({swap_done, packed_b_coeffs, packed_a_coeffs} !== {1'b1, 14'h2BCD, 14'h1234, 14'h0F0F}) begin
            miscompares++;
            $display("FAIL pend_swap got swap=%b b=%h a=%h expected 1/%h/%h",
                     swap_done, packed_b_coeffs, packed_a_coeffs, {14'h2BCD, 14'h1234}, 14'h0F0F);
        end
    endtask

    task automatic test_back_to_back();
        apply_cycle(1, 14'd9, 0, 0);
        apply_cycle(1, 14'd8, 0, 0);
        apply_cycle(1, 14'd7, 1, 0);
        do_reset();
        swaps_seen = 0;
        for (int i = 0; i < 4; i++) apply_cycle(0, '0, 0, 1);
        vectors++;
        if ({swaps_seen[3:0], packed_b_coeffs, packed_a_coeffs} !== {4'd0, 42'd0}) begin
            miscompares++;
            $display("FAIL reset_in_pend got swaps=%0d b=%h a=%h expected 0/0/0",
                     swaps_seen, packed_b_coeffs, packed_a_coeffs);
        end
        apply_cycle(1, 14'd11, 0, 0);
        apply_cycle(1, 14'd12, 0, 0);
        apply_cycle(1, 14'd13, 1, 0);
        apply_cycle(0, '0, 0, 1);
        apply_cycle(1, -14'sd21, 0, 0);
        apply_cycle(1, 14'd22, 0, 0);
        apply_cycle(1, -14'sd23, 1, 0);
        apply_cycle(0, '0, 0, 1);
        apply_cycle(0, '0, 0, 0);
        vectors++;
        if ({swaps_seen[3:0], packed_b_coeffs, packed_a_coeffs} !== {4'd2, 14'd22, 14'h3FEB, 14'h3FE9}) begin
            miscompares++;
            $display("FAIL back_to_back got swaps=%0d b=%h a=%h expected 2/%h/%h",
                     swaps_seen, packed_b_coeffs, packed_a_coeffs, {14'd22, 14'h3FEB}, 14'h3FE9);
        end
    endtask

    task automatic test_random();
        bit v;
        bit l;
        bit s;
        logic [CW-1:0] w;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            w = CW'($urandom);
            l = (idx_m == N - 1) ^ ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 3) == 0);
            apply_cycle(v, w, l, s);
        end
    endtask

    initial begin
        model_clear();
        swaps_seen = 0;
        test_reset();
        test_normal();
        test_early_last();
        test_missing_last();
        test_simul_strobe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
